// File: rtl/data_sender_multi.sv
// Serialises a BYTES*WIDTH word into WIDTH-bit bytes under downstream handshake,
// with an optional header byte and a one-deep pending buffer for back-to-back frames.
module data_sender_multi #(
    parameter int               BYTES     = 5,
    parameter int               WIDTH     = 8,
    parameter int               MSB_FIRST = 0,
    parameter int               HEADER_EN = 0,
    parameter logic [WIDTH-1:0] HEADER    = WIDTH'(8'hAA)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTES*WIDTH-1:0]   dataIn,
    input  logic                     transmissionStart,
    input  logic                     transmissionDone,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     busy,
    output logic                     pendingFull,
    output logic                     frameDone,
    output logic                     overrun
);

    localparam int N     = BYTES + ((HEADER_EN != 0) ? 1 : 0);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, nxt_state;
    logic [IDX_W-1:0]       idx, nxt_idx;
    logic [BYTES*WIDTH-1:0] active, nxt_active;
    logic [BYTES*WIDTH-1:0] pending, nxt_pending;
    logic                   nxt_pfull, nxt_frame_done, nxt_overrun;

    function automatic logic [WIDTH-1:0] slot_byte(input logic [BYTES*WIDTH-1:0] word,
                                                   input logic [IDX_W-1:0]       k);
        int d;
        int b;
        if (HEADER_EN != 0 && k == '0)
            return HEADER;
        d = int'(k) - ((HEADER_EN != 0) ? 1 : 0);
        b = (MSB_FIRST != 0) ? (BYTES - 1 - d) : d;
        return word[b*WIDTH +: WIDTH];
    endfunction

    always_comb begin
        nxt_state      = state;
        nxt_idx        = idx;
        nxt_active     = active;
        nxt_pending    = pending;
        nxt_pfull      = pendingFull;
        nxt_frame_done = 1'b0;
        nxt_overrun    = overrun;

        unique case (state)
            IDLE: begin
                if (transmissionStart) begin
                    nxt_active = dataIn;
                    nxt_idx    = '0;
                    nxt_state  = SEND;
                end
            end
            SEND: begin
                if (transmissionDone && idx == LAST) begin
                    // Final acknowledge: promote pending first, then a coincident start
                    // refills whichever register became free.
                    nxt_frame_done = 1'b1;
                    nxt_idx        = '0;
                    if (pendingFull) begin
                        nxt_active = pending;
                        if (transmissionStart)
                            nxt_pending = dataIn;
                        else
                            nxt_pfull = 1'b0;
                    end else if (transmissionStart) begin
                        nxt_active = dataIn;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    if (transmissionDone)
                        nxt_idx = idx + 1'b1;
                    if (transmissionStart) begin
                        if (!pendingFull) begin
                            nxt_pending = dataIn;
                            nxt_pfull   = 1'b1;
                        end else begin
                            nxt_overrun = 1'b1;
                        end
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            active      <= '0;
            pending     <= '0;
            pendingFull <= 1'b0;
            frameDone   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            dataOut     <= '0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            active      <= nxt_active;
            pending     <= nxt_pending;
            pendingFull <= nxt_pfull;
            frameDone   <= nxt_frame_done;
            overrun     <= nxt_overrun;
            busy        <= (nxt_state == SEND);
            if (nxt_state == SEND)
                dataOut <= slot_byte(nxt_active, nxt_idx);
        end
    end

endmodule

// File: tb/tb_data_sender_multi.sv
// Directed bench for data_sender_multi: default LSB-first instance plus an
// MSB-first instance with a header byte.
module tb_data_sender_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] data_in = '0;
    logic        start = 1'b0, done = 1'b0;
    logic        start2 = 1'b0, done2 = 1'b0;

    logic [7:0]  data_out, data_out2;
    logic        busy, busy2, pfull, pfull2, fdone, fdone2, ovr, ovr2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    data_sender_multi u_dut (
        .clk(clk), .rst(rst), .dataIn(data_in),
        .transmissionStart(start), .transmissionDone(done),
        .dataOut(data_out), .busy(busy), .pendingFull(pfull),
        .frameDone(fdone), .overrun(ovr)
    );

    data_sender_multi #(.MSB_FIRST(1), .HEADER_EN(1)) u_dut_hdr (
        .clk(clk), .rst(rst), .dataIn(data_in),
        .transmissionStart(start2), .transmissionDone(done2),
        .dataOut(data_out2), .busy(busy2), .pendingFull(pfull2),
        .frameDone(fdone2), .overrun(ovr2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #3;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] seq [5];

        // Reset state
        do_reset();
        check("rst_dout", data_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pfull", pfull, 1'b0);
        check("rst_fdone", fdone, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_dout2", data_out2, 8'h00);

        // Header + MSB-first frame
        data_in = 40'h1122334455;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("hdr_b0", data_out2, 8'hAA);
        done2 = 1'b1;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hdr_b%0d", i + 1), data_out2, 64'(seq[i]));
        end
        step();
        done2 = 1'b0;
        check("hdr_fdone", fdone2, 1'b1);
        check("hdr_busy", busy2, 1'b0);
        check("hdr_hold", data_out2, 8'h55);

        // Basic LSB-first frame, done held high across bytes
        start = 1'b1;
        step();
        start = 1'b0;
        data_in = 40'hFFFFFFFFFF;
        check("basic_b0", data_out, 8'h55);
        check("basic_busy", busy, 1'b1);
        done = 1'b1;
        seq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("basic_b%0d", i + 1), data_out, 64'(seq[i]));
            check("basic_nofd", fdone, 1'b0);
        end
        step();
        done = 1'b0;
        check("basic_fdone", fdone, 1'b1);
        check("basic_idle", busy, 1'b0);
        check("basic_hold", data_out, 8'h11);
        step();
        check("basic_fd_pulse", fdone, 1'b0);

        // Acknowledge in IDLE is ignored
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        check("idle_ack_busy", busy, 1'b0);
        check("idle_ack_dout", data_out, 8'h11);

        // Pending word, overrun on third start, back-to-back frames
        data_in = 40'h1122334455;
        start = 1'b1;
        step();
        data_in = 40'h1234123412;
        step();
        check("pend_full", pfull, 1'b1);
        check("pend_dout", data_out, 8'h55);
        data_in = 40'hDEADBEEF00;
        step();
        start = 1'b0;
        check("ovr_set", ovr, 1'b1);
        check("ovr_pfull", pfull, 1'b1);
        done = 1'b1;
        seq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b2b_a%0d", i + 1), data_out, 64'(seq[i]));
        end
        step();
        check("b2b_fd1", fdone, 1'b1);
        check("b2b_busy", busy, 1'b1);
        check("b2b_next", data_out, 8'h12);
        check("b2b_pempty", pfull, 1'b0);
        seq = '{8'h34, 8'h12, 8'h34, 8'h12, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b2b_b%0d", i + 1), data_out, 64'(seq[i]));
        end
        step();
        done = 1'b0;
        check("b2b_fd2", fdone, 1'b1);
        check("b2b_idle", busy, 1'b0);
        check("ovr_sticky", ovr, 1'b1);

        // Reset mid-frame with a pending word
        data_in = 40'h1122334455;
        start = 1'b1;
        step();
        start = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        check("mid_b1", data_out, 8'h44);
        data_in = 40'h0102030405;
        start = 1'b1;
        step();
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_dout", data_out, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_pfull", pfull, 1'b0);
        check("arst_ovr", ovr, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        data_in = 40'hA1A2A3A4A5;
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_b0", data_out, 8'hA5);
        done = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("post_b4", data_out, 8'hA1);
        step();
        check("post_fdone", fdone, 1'b1);
        check("post_nopend", busy, 1'b0);
        check("post_fd_after_rst", fdone2, 1'b0);

        // Start coincident with final acknowledge, pending empty
        data_in = 40'h1122334455;
        start = 1'b1;
        done = 1'b0;
        step();
        start = 1'b0;
        done = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("coin_last", data_out, 8'h11);
        data_in = 40'h5566778899;
        start = 1'b1;
        step();
        start = 1'b0;
        done = 1'b0;
        check("coin_b0", data_out, 8'h99);
        check("coin_fdone", fdone, 1'b1);
        check("coin_busy", busy, 1'b1);

        // Start coincident with final acknowledge, pending full
        data_in = 40'h0A0B0C0D0E;
        start = 1'b1;
        step();
        start = 1'b0;
        done = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("coin2_last", data_out, 8'h55);
        data_in = 40'h1F2F3F4F5F;
        start = 1'b1;
        step();
        start = 1'b0;
        check("coin2_b0", data_out, 8'h0E);
        check("coin2_fdone", fdone, 1'b1);
        check("coin2_pfull", pfull, 1'b1);
        check("coin2_noovr", ovr, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("coin2_pend_b0", data_out, 8'h5F);
        check("coin2_fd", fdone, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("coin2_pend_b4", data_out, 8'h1F);
        step();
        done = 1'b0;
        check("coin2_end_fd", fdone, 1'b1);
        check("coin2_end_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
